// File: rtl/reg_file_bypass_if.sv
// Register file access bundle: two read ports, one write-back port and,
// when REGFILE_DEBUG_EN is defined, a debug read port plus write counter.
// master = pipeline side driving addresses/write data; slave = register file.
interface reg_file_bypass_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [AW-1:0]    A3;
  logic             WE3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
`ifdef REGFILE_DEBUG_EN
  logic [AW-1:0]    DbgA;
  logic [WIDTH-1:0] DbgRD;
  logic [31:0]      WrCount;

  modport master (
    output A1, A2, A3, WE3, WD3, DbgA,
    input  RD1, RD2, DbgRD, WrCount
  );

  modport slave (
    input  A1, A2, A3, WE3, WD3, DbgA,
    output RD1, RD2, DbgRD, WrCount
  );
`else
  modport master (
    output A1, A2, A3, WE3, WD3,
    input  RD1, RD2
  );

  modport slave (
    input  A1, A2, A3, WE3, WD3,
    output RD1, RD2
  );
`endif
endinterface

// File: rtl/reg_file_bypass.sv
// Decode-stage MIPS register file with WB->ID write-through bypass.
// Reads are combinational; a write presented this cycle is visible on the
// read ports immediately, so forwarding muxes only cover MEM/EX sources.
// r0 is hardwired to zero. Optional macro REGFILE_DEBUG_EN adds a third
// read port (DbgA/DbgRD) and a committed-write counter (WrCount).
module reg_file_bypass #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_bypass_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_commit;

  // Read function: reset and r0 force zero, then bypass, then stored value.
  function automatic logic [WIDTH-1:0] rd_f(
    input logic             rst,
    input logic [AW-1:0]    a,
    input logic             we,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd,
    input logic [WIDTH-1:0] stored
  );
    if (rst || a == '0)          return '0;
    else if (we == 1'b1 && wa == a) return wd;
    else                         return stored;
  endfunction

  // A write commits only with a known-high enable and a non-zero address.
  always_comb begin
    wr_commit = (bus.WE3 == 1'b1) && (bus.A3 != '0);
  end

  // Next-state array: copy of current contents with the committed write applied.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit) regs_d[bus.A3] = bus.WD3;
  end

  // Array storage; asynchronous reset reloads every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports 1 and 2.
  always_comb begin
    bus.RD1 = rd_f(reset, bus.A1, bus.WE3, bus.A3, bus.WD3, regs_q[bus.A1]);
    bus.RD2 = rd_f(reset, bus.A2, bus.WE3, bus.A3, bus.WD3, regs_q[bus.A2]);
  end

`ifdef REGFILE_DEBUG_EN
  logic [31:0] wr_count_q;
  logic [31:0] wr_count_d;

  // Committed-write counter next state; wraps naturally at 32 bits.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit) wr_count_d = wr_count_q + 32'd1;
  end

  // Committed-write counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_count_q <= '0;
    else       wr_count_q <= wr_count_d;
  end

  // Debug read port, same priority as the pipeline ports.
  always_comb begin
    bus.DbgRD   = rd_f(reset, bus.DbgA, bus.WE3, bus.A3, bus.WD3, regs_q[bus.DbgA]);
    bus.WrCount = wr_count_q;
  end
`endif

  // An unknown write enable outside reset is a pipeline bug.
  a_we3_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(bus.WE3));

endmodule

// File: tb/tb_reg_file_bypass.sv
// Scoreboard bench for reg_file_bypass: expected read values are pushed when
// addresses are driven and popped when the outputs are sampled.
module tb_reg_file_bypass;

  logic clk;
  logic reset;

  reg_file_bypass_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file_bypass #(.WIDTH(32), .DEPTH(32), .RST_VAL('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  logic [31:0] wcnt;
  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (reset || a == 5'd0)                return 32'd0;
    if (bus.WE3 === 1'b1 && bus.A3 == a)   return bus.WD3;
    return mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    wcnt = 32'd0;
  endtask

  // Drive read addresses, queue expectations, sample, pop and compare.
  task automatic probe(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    bus.A1 = a1;
    bus.A2 = a2;
    sb.push_back('{tag: {tag, ".rd1"}, exp: model_rd(a1)});
    sb.push_back('{tag: {tag, ".rd2"}, exp: model_rd(a2)});
`ifdef REGFILE_DEBUG_EN
    bus.DbgA = a1;
    sb.push_back('{tag: {tag, ".dbg"}, exp: model_rd(a1)});
`endif
    #1;
    e = sb.pop_front(); check(e.tag, bus.RD1, e.exp);
    e = sb.pop_front(); check(e.tag, bus.RD2, e.exp);
`ifdef REGFILE_DEBUG_EN
    e = sb.pop_front(); check(e.tag, bus.DbgRD, e.exp);
`endif
  endtask

  // One clock: commit into the model at the edge, return at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (!reset && bus.WE3 === 1'b1 && bus.A3 != 5'd0) begin
      mdl[bus.A3] = bus.WD3;
      wcnt = wcnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.WE3 = 1'b1; bus.A3 = a; bus.WD3 = d;
    tick();
    bus.WE3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef REGFILE_DEBUG_EN
    logic [31:0] cnt0;
`endif
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    reset   = 1'b1;
    bus.A1  = '0; bus.A2 = '0; bus.A3 = '0;
    bus.WE3 = 1'b0; bus.WD3 = '0;
`ifdef REGFILE_DEBUG_EN
    bus.DbgA = '0;
`endif

    @(negedge clk);
    probe("rst_hold", 5'd5, 5'd31);
    reset = 1'b0;
    probe("post_rst", 5'd1, 5'd2);

    // Reset mid-cycle clears a written register immediately.
    wr(5'd5, 32'hDEADBEEF);
    probe("r5_written", 5'd5, 5'd0);
    #2;
    reset = 1'b1;
    model_clear();
    probe("rst_mid", 5'd5, 5'd5);
`ifdef REGFILE_DEBUG_EN
    check("wrcnt_rst", bus.WrCount, 32'd0);
`endif
    // Write presented during reset: reads stay zero and nothing commits.
    bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hCAFEF00D;
    probe("rst_no_byp", 5'd5, 5'd0);
    tick();
    // First edge after release commits.
    reset = 1'b0;
    bus.WD3 = 32'h0BADC0DE;
    probe("rel_byp", 5'd5, 5'd0);
    tick();
    bus.WE3 = 1'b0;
    probe("rel_wr", 5'd5, 5'd4);

    // Basic write/read.
    wr(5'd8, 32'h12345678);
    probe("basic", 5'd8, 5'd9);

    // r0 is immutable, even against the bypass.
    bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hFFFFFFFF;
    probe("r0_byp", 5'd0, 5'd0);
`ifdef REGFILE_DEBUG_EN
    cnt0 = wcnt;
`endif
    tick();
    bus.WE3 = 1'b0;
    probe("r0", 5'd0, 5'd8);
`ifdef REGFILE_DEBUG_EN
    check("wrcnt_r0", bus.WrCount, cnt0);
`endif

    // Same-cycle bypass on both ports.
    wr(5'd3, 32'h11);
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h22;
    probe("byp", 5'd3, 5'd3);
    tick();
    bus.WE3 = 1'b0;
    probe("byp_after", 5'd3, 5'd3);

    // Back-to-back writes to r31.
`ifdef REGFILE_DEBUG_EN
    cnt0 = wcnt;
`endif
    bus.WE3 = 1'b1; bus.A3 = 5'd31; bus.WD3 = 32'hA;
    tick();
    bus.WD3 = 32'hB;
    tick();
    bus.WE3 = 1'b0;
    probe("b2b", 5'd31, 5'd31);
`ifdef REGFILE_DEBUG_EN
    check("wrcnt_b2b", bus.WrCount, cnt0 + 32'd2);
`endif

    // Random traffic with reads aimed at the write address part of the time.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a1;
      logic [4:0] a2;
      bus.WE3 = 1'($urandom_range(0, 1));
      bus.A3  = 5'($urandom_range(0, 31));
      bus.WD3 = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? bus.A3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? bus.A3 : 5'($urandom_range(0, 31));
      probe("rand", a1, a2);
      tick();
    end
    bus.WE3 = 1'b0;
    probe("rand_end", 5'd31, 5'd3);

`ifdef REGFILE_DEBUG_EN
    check("wrcnt_rand", bus.WrCount, wcnt);
    // Counter wrap.
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_q;
    wcnt = 32'hFFFFFFFF;
    check("wrcnt_forced", bus.WrCount, wcnt);
    wr(5'd31, 32'h77);
    check("wrcnt_wrap", bus.WrCount, 32'd0);
    probe("dbg31", 5'd31, 5'd31);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
